rf_wr_arbiter: RTL and testbench

- Shares the single register-file write port between two sources:
  - the pipeline writeback stage, which has fixed priority;
  - the AXI master load-response path, whose long-latency results are buffered in a small FIFO.
- Keeps a 32-entry pending scoreboard of registers with an outstanding AXI load.
- Raises a decode-stage stall on RAW/WAW hazards against those registers.
- Sits between the writeback stage, the AXI master, the hazard unit and the register file's write port.

---
 rtl/rf_arb_pkg.sv | 11 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/rf_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_wr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared widths and the buffered AXI load-response entry for the register-file write arbiter.
package rf_arb_pkg;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rsp_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers; the head is visible only the cycle after a push.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback has priority, buffered AXI load responses fill idle slots,
// and a pending scoreboard stalls decode on hazards against outstanding loads.
module rf_wr_arbiter import rf_arb_pkg::*; #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wb_we_i,
   input  logic [ADDR_W-1:0]             wb_addr_i,
   input  logic [DATA_W-1:0]             wb_data_i,
   input  logic                          axi_issue_i,
   input  logic [ADDR_W-1:0]             axi_issue_addr_i,
   output logic                          axi_issue_ready_o,
   input  logic                          axi_rsp_valid_i,
   output logic                          axi_rsp_ready_o,
   input  logic [ADDR_W-1:0]             axi_rsp_addr_i,
   input  logic [DATA_W-1:0]             axi_rsp_data_i,
   input  logic [ADDR_W-1:0]             id_addr_a_i,
   input  logic [ADDR_W-1:0]             id_addr_b_i,
   input  logic [ADDR_W-1:0]             id_addr_d_i,
   input  logic                          id_reg_we_i,
   output logic                          stall_o,
   output logic                          rf_we_o,
   output logic [ADDR_W-1:0]             rf_addr_o,
   output logic [DATA_W-1:0]             rf_data_o,
   output logic [NUM_REGS-1:0]           pending_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                w_wb_hit;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_pop;
   logic                w_rsp_fire;
   logic                w_push;
   logic                w_set;
   logic                w_clr;
   rsp_t                w_push_ent;
   rsp_t                w_head;
   logic [CNT_W-1:0]    w_fifo_count;
   logic [CNT_W-1:0]    r_outstanding;
   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;

   // Handshakes: a response transfers on a clock edge where axi_rsp_valid_i && axi_rsp_ready_o;
   // an issue is a one-cycle strobe that the AXI master raises only while axi_issue_ready_o is high.
   assign w_wb_hit        = wb_we_i && (wb_addr_i != '0);
   assign w_pop           = !w_wb_hit && !w_fifo_empty;
   assign axi_rsp_ready_o = !w_fifo_full;
   assign w_rsp_fire      = axi_rsp_valid_i && !w_fifo_full;
   assign w_push          = w_rsp_fire && (axi_rsp_addr_i != '0);
   assign w_push_ent      = '{addr: axi_rsp_addr_i, data: axi_rsp_data_i};

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(rsp_t))
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_push_ent),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   always_comb begin
      rf_we_o   = 1'b0;
      rf_addr_o = '0;
      rf_data_o = '0;
      if (w_wb_hit) begin
         rf_we_o   = 1'b1;
         rf_addr_o = wb_addr_i;
         rf_data_o = wb_data_i;
      end else if (!w_fifo_empty) begin
         rf_we_o   = 1'b1;
         rf_addr_o = w_head.addr;
         rf_data_o = w_head.data;
      end
   end

   // x0 is never pushed, so a FIFO write always clears a real scoreboard bit.
   assign w_set = axi_issue_i && (axi_issue_addr_i != '0);
   assign w_clr = w_pop;

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (w_set) w_set_mask[axi_issue_addr_i] = 1'b1;
      if (w_clr) w_clr_mask[w_head.addr]      = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending     <= '0;
         r_outstanding <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
         case ({w_set, w_clr})
            2'b10:   r_outstanding <= r_outstanding + 1'b1;
            2'b01:   r_outstanding <= r_outstanding - 1'b1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign axi_issue_ready_o = (r_outstanding < CNT_W'(FIFO_DEPTH)) && !r_pending[axi_issue_addr_i];
   assign pending_o         = r_pending;
   assign fifo_count_o      = w_fifo_count;

   assign stall_o = ((id_addr_a_i != '0) && r_pending[id_addr_a_i]) ||
                    ((id_addr_b_i != '0) && r_pending[id_addr_b_i]) ||
                    (id_reg_we_i && (id_addr_d_i != '0) && r_pending[id_addr_d_i]);

   a_wb_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_wb_hit && r_pending[wb_addr_i]));
   a_issue_when_ready: assert property (@(posedge clk) disable iff (!rst_n)
      !(axi_issue_i && !axi_issue_ready_o));
   a_set_clr_distinct: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_set && w_clr && (axi_issue_addr_i == w_head.addr)));

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed and randomized bench for rf_wr_arbiter against a queue-based model of the write port.
module tb_rf_wr_arbiter;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wb_we;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          issue;
   logic [AW-1:0] issue_addr;
   logic          issue_ready;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] id_a;
   logic [AW-1:0] id_b;
   logic [AW-1:0] id_d;
   logic          id_we;
   logic          stall;
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   logic [31:0]   pending;
   logic [CW-1:0] fifo_count;

   always #5 clk = ~clk;

   rf_wr_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .wb_we_i           (wb_we),
      .wb_addr_i         (wb_addr),
      .wb_data_i         (wb_data),
      .axi_issue_i       (issue),
      .axi_issue_addr_i  (issue_addr),
      .axi_issue_ready_o (issue_ready),
      .axi_rsp_valid_i   (rsp_valid),
      .axi_rsp_ready_o   (rsp_ready),
      .axi_rsp_addr_i    (rsp_addr),
      .axi_rsp_data_i    (rsp_data),
      .id_addr_a_i       (id_a),
      .id_addr_b_i       (id_b),
      .id_addr_d_i       (id_d),
      .id_reg_we_i       (id_we),
      .stall_o           (stall),
      .rf_we_o           (rf_we),
      .rf_addr_o         (rf_addr),
      .rf_data_o         (rf_data),
      .pending_o         (pending),
      .fifo_count_o      (fifo_count)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Model: set of registers awaiting their FIFO write, buffered responses, loads not yet answered.
   logic [31:0]         m_pend;
   logic [AW+DW-1:0]    exp_q[$];
   logic [AW-1:0]       infl_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      issue = 1'b0; issue_addr = '0;
      rsp_valid = 1'b0; rsp_addr = '0; rsp_data = '0;
      id_a = '0; id_b = '0; id_d = '0; id_we = 1'b0;
   endtask

   task automatic model_clear();
      m_pend = '0;
      exp_q.delete();
      infl_q.delete();
   endtask

   function automatic logic model_issue_ready(input logic [AW-1:0] a);
      return ($countones(m_pend) < DEPTH) && !m_pend[a];
   endfunction

   task automatic check_model();
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic          e_stall;
      logic [AW+DW-1:0] h;
      e_we = 1'b0; e_addr = '0; e_data = '0;
      if (wb_we && wb_addr != 0) begin
         e_we = 1'b1; e_addr = wb_addr; e_data = wb_data;
      end else if (exp_q.size() > 0) begin
         h = exp_q[0];
         e_we = 1'b1; e_addr = h[AW+DW-1:DW]; e_data = h[DW-1:0];
      end
      e_stall = (id_a != 0 && m_pend[id_a]) || (id_b != 0 && m_pend[id_b]) ||
                (id_we && id_d != 0 && m_pend[id_d]);
      chk("rf_we", 64'(rf_we), 64'(e_we));
      chk("rf_addr", 64'(rf_addr), 64'(e_addr));
      chk("rf_data", 64'(rf_data), 64'(e_data));
      chk("stall", 64'(stall), 64'(e_stall));
      chk("pending", 64'(pending), 64'(m_pend));
      chk("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
      chk("rsp_ready", 64'(rsp_ready), 64'(exp_q.size() < DEPTH));
      chk("issue_ready", 64'(issue_ready), 64'(model_issue_ready(issue_addr)));
   endtask

   // Check the current cycle, advance the model by the applied inputs, then cross the clock edge.
   task automatic cycle();
      logic acc;
      logic [AW+DW-1:0] h;
      #1;
      check_model();
      acc = rsp_valid && (exp_q.size() < DEPTH);
      if (!(wb_we && wb_addr != 0) && exp_q.size() > 0) begin
         h = exp_q.pop_front();
         m_pend[h[AW+DW-1:DW]] = 1'b0;
      end
      if (acc && rsp_addr != 0) begin
         exp_q.push_back({rsp_addr, rsp_data});
         for (int i = 0; i < infl_q.size(); i++)
            if (infl_q[i] == rsp_addr) begin
               infl_q.delete(i);
               break;
            end
      end
      if (issue && issue_addr != 0) begin
         m_pend[issue_addr] = 1'b1;
         infl_q.push_back(issue_addr);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [AW-1:0] a;
      int            k;
      idle();
      model_clear();

      // Reset values
      #12;
      chk("rst_hold_count", 64'(fifo_count), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_rf_we", 64'(rf_we), 64'h0);
      chk("rst_rf_addr", 64'(rf_addr), 64'h0);
      chk("rst_rf_data", 64'(rf_data), 64'h0);
      chk("rst_stall", 64'(stall), 64'h0);
      chk("rst_rsp_ready", 64'(rsp_ready), 64'h1);
      chk("rst_issue_ready", 64'(issue_ready), 64'h1);
      chk("rst_pending", 64'(pending), 64'h0);

      // Issue x5, then hazard on rs1
      issue = 1'b1; issue_addr = 5'd5;
      cycle();
      idle(); id_a = 5'd5;
      #1;
      chk("x5_pending", 64'(pending), 64'h20);
      chk("x5_stall", 64'(stall), 64'h1);
      for (int i = 0; i < 10; i++) cycle();
      rsp_valid = 1'b1; rsp_addr = 5'd5; rsp_data = 32'hDEAD_BEEF;
      cycle();
      rsp_valid = 1'b0;
      #1;
      chk("ld_rf_we", 64'(rf_we), 64'h1);
      chk("ld_rf_addr", 64'(rf_addr), 64'h5);
      chk("ld_rf_data", 64'(rf_data), 64'hDEAD_BEEF);
      cycle();
      chk("ld_pending_clr", 64'(pending), 64'h0);
      chk("ld_stall_clr", 64'(stall), 64'h0);

      // WB priority over a buffered response
      idle();
      issue = 1'b1; issue_addr = 5'd7;
      cycle();
      idle();
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
      rsp_valid = 1'b1; rsp_addr = 5'd7; rsp_data = 32'h11;
      cycle();
      rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wbp_addr", 64'(rf_addr), 64'h3);
         chk("wbp_count", 64'(fifo_count), 64'h1);
         cycle();
      end
      wb_we = 1'b0;
      #1;
      chk("wbp_drain_addr", 64'(rf_addr), 64'h7);
      chk("wbp_drain_data", 64'(rf_data), 64'h11);
      cycle();
      chk("wbp_count_after", 64'(fifo_count), 64'h0);

      // Outstanding limit and full FIFO
      idle();
      for (int i = 1; i <= 4; i++) begin
         issue = 1'b1; issue_addr = AW'(i);
         cycle();
      end
      issue = 1'b0; issue_addr = 5'd6;
      #1;
      chk("lim_issue_ready", 64'(issue_ready), 64'h0);
      wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'hA5A5;
      for (int i = 1; i <= 4; i++) begin
         rsp_valid = 1'b1; rsp_addr = AW'(i); rsp_data = 32'h100 + 32'(i);
         cycle();
      end
      rsp_valid = 1'b0;
      #1;
      chk("full_count", 64'(fifo_count), 64'h4);
      chk("full_rsp_ready", 64'(rsp_ready), 64'h0);
      wb_we = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk("drain_addr", 64'(rf_addr), 64'(i));
         chk("drain_count", 64'(fifo_count), 64'(5 - i));
         cycle();
      end

      // WAW and duplicate issue
      idle();
      issue = 1'b1; issue_addr = 5'd9;
      cycle();
      issue = 1'b0; issue_addr = 5'd9; id_we = 1'b1; id_d = 5'd9;
      #1;
      chk("dup_issue_ready", 64'(issue_ready), 64'h0);
      chk("waw_stall", 64'(stall), 64'h1);
      cycle();
      id_a = '0; id_b = '0; id_d = '0;
      #1;
      chk("x0_ops_stall", 64'(stall), 64'h0);
      cycle();
      idle();
      rsp_valid = 1'b1; rsp_addr = 5'd9; rsp_data = 32'h99;
      cycle();
      idle();
      cycle();

      // Response to x0 is swallowed
      rsp_valid = 1'b1; rsp_addr = '0; rsp_data = 32'h55;
      #1;
      chk("x0_rsp_ready", 64'(rsp_ready), 64'h1);
      cycle();
      idle();
      #1;
      chk("x0_count", 64'(fifo_count), 64'h0);
      chk("x0_rf_we", 64'(rf_we), 64'h0);
      cycle();

      // Reset with two responses buffered
      issue = 1'b1; issue_addr = 5'd12;
      cycle();
      issue_addr = 5'd13;
      wb_we = 1'b1; wb_addr = 5'd20; wb_data = 32'h2020;
      rsp_valid = 1'b1; rsp_addr = 5'd12; rsp_data = 32'hC12;
      cycle();
      issue = 1'b0; rsp_addr = 5'd13; rsp_data = 32'hC13;
      cycle();
      idle();
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("mid_rst_count", 64'(fifo_count), 64'h0);
      chk("mid_rst_pending", 64'(pending), 64'h0);
      chk("mid_rst_rf_we", 64'(rf_we), 64'h0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cycle();
      chk("post_rst_rf_we", 64'(rf_we), 64'h0);

      // Randomized traffic obeying the legal-use rules
      for (int n = 0; n < 600; n++) begin
         idle();
         a = AW'($urandom_range(0, 31));
         issue_addr = a;
         issue = ($urandom_range(0, 2) == 0) && model_issue_ready(a);
         if (infl_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            k = $urandom_range(0, infl_q.size() - 1);
            rsp_valid = 1'b1; rsp_addr = infl_q[k]; rsp_data = $urandom;
         end else if ($urandom_range(0, 15) == 0) begin
            rsp_valid = 1'b1; rsp_addr = '0; rsp_data = $urandom;
         end
         if ($urandom_range(0, 1) == 1) begin
            do a = AW'($urandom_range(0, 31)); while (m_pend[a]);
            wb_we = 1'b1; wb_addr = a; wb_data = $urandom;
         end
         id_a = AW'($urandom_range(0, 31));
         id_b = AW'($urandom_range(0, 31));
         id_d = AW'($urandom_range(0, 31));
         id_we = 1'(($urandom_range(0, 1)));
         cycle();
      end

      // Answer every outstanding load and let the FIFO empty
      idle();
      k = 0;
      while (infl_q.size() > 0 && k < 100) begin
         rsp_valid = 1'b1; rsp_addr = infl_q[0]; rsp_data = $urandom;
         cycle();
         k++;
      end
      if (k >= 100) chk("drain_timeout", 64'(infl_q.size()), 64'h0);
      idle();
      for (int i = 0; i < 8; i++) cycle();
      chk("end_pending", 64'(pending), 64'h0);
      chk("end_count", 64'(fifo_count), 64'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
